mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing a single-port, fixed-latency instruction/data SRAM between the IF stage (instruction fetch) and the MEM stage (load/store). It serialises accesses, drives the SRAM for a parameterised number of cycles, and returns one-cycle acknowledges. It also generates the `freeze` that holds the PC register and the `mem_stall` that holds the later pipeline stages while an access is outstanding.

## Interface
- `LAT`, 2: SRAM access cycles (address/enable held stable this long); legal range 1..15
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level, held until `if_ack`
- `if_addr`  in  32  fetch byte address
- `if_rdata`  out  32  fetched instruction, valid while `if_ack`=1
- `if_ack`  out  1  one-cycle fetch completion pulse
- `mem_req`  in  1  load/store request, level, held until `mem_ack`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_addr`  in  32  load/store byte address
- `mem_wdata`  in  32  store data
- `mem_rdata`  out  32  load data, valid while `mem_ack`=1 (0 for stores)
- `mem_ack`  out  1  one-cycle load/store completion pulse
- `freeze`  out  1  `if_req & ~if_ack` (combinational), to PC register
- `mem_stall`  out  1  `mem_req & ~mem_ack` (combinational), to pipeline
- `sram_en`  out  1  SRAM access enable
- `sram_we`  out  1  SRAM write enable
- `sram_addr`  out  32  SRAM address
- `sram_wdata`  out  32  SRAM write data
- `sram_rdata`  in  32  SRAM read data, valid in last enabled cycle

## Operation
- States: IDLE, BUSY, ACK. A 4-bit counter `cnt` is used in BUSY.
- IDLE, no request: stay IDLE with SRAM outputs 0.
- IDLE, request(s) present: select the owner and latch its address, `we` (0 for IF) and wdata into internal registers. Clear `cnt`. Go to BUSY.
- Selection rules:
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted last time wins.
  - The `last` bit resets to IF, so the first tie goes to MEM.
  - `last` updates on every grant.
- BUSY:
  - `sram_en`=1. `sram_we`, `sram_addr`, `sram_wdata` come from the latched registers, not the live inputs.
  - `cnt` increments each cycle.
  - When `cnt`==LAT-1: capture `sram_rdata` into the owner's rdata register (0 for stores), then go to ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle; `sram_en`=0.
  - No grant is made in ACK. Go to IDLE.
  - Requester changes or drops `req`/`addr` in the following cycle.
- Request inputs changing during BUSY/ACK have no effect on the access in flight.
- `if_rdata`/`mem_rdata` hold their last captured value outside ACK. Only ack qualifies them.
- Never both acks in the same cycle; never `sram_en` in IDLE or ACK.
- Reset (`rst`=0, any state, asynchronous):
  - State goes to IDLE; `cnt`=0; `last`=IF.
  - All registered outputs go to 0, including both rdata, both acks, and all `sram_*`.
  - An in-flight access is abandoned with no ack. The requester still holds `req`, so the access is re-granted after reset release.

## Timing
- Request seen in IDLE at cycle 0 → `sram_en` cycles 1..LAT → ack in cycle LAT+1.
- Isolated access latency is LAT+1 cycles; back-to-back throughput is one access per LAT+2 cycles.
- Contended pair: the second owner's ack arrives at cycle 2·(LAT+2)-1 after the common request cycle.
- `freeze`/`mem_stall` fall in the same cycle as the corresponding ack, so the PC/pipeline registers advance on that edge.
- Reset values: `if_ack`=`mem_ack`=0, `if_rdata`=`mem_rdata`=0, `sram_en`=`sram_we`=0, `sram_addr`=`sram_wdata`=0.
- `freeze`/`mem_stall` follow their requests, so both are 0 when no request is present.

## Test plan
- IF-only fetch, LAT=2, `if_addr`=0x10, SRAM returns 0xE3A01005 → `sram_en` high cycles 1–2 with addr 0x10; `if_ack`=1 in cycle 3 with `if_rdata`=0xE3A01005; `freeze`=1 cycles 0–2, 0 in cycle 3.
- Simultaneous `if_req` and `mem_req` (load 0x400) at reset exit, LAT=2 → MEM acked in cycle 3; IF granted in cycle 4 and acked in cycle 7; `if_ack` and `mem_ack` never overlap.
- Store: `mem_we`=1, addr 0x404, wdata 0xDEADBEEF → `sram_we`=1 with wdata stable for exactly LAT cycles; `mem_ack` pulse; `mem_rdata`=0.
- Starvation: `mem_req` re-asserted immediately after every ack while `if_req` is held → grants strictly alternate MEM, IF, MEM, IF.
- Input churn: `if_addr` changed during BUSY → `sram_addr` keeps the latched address.
- Reset mid-BUSY: `rst` low for 1 cycle in BUSY → `sram_en` drops immediately and no ack is issued; the held request is re-served from IDLE with full LAT+1 latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency SRAM between instruction fetch and load/store.
// Requests are serialised, alternating grants on contention, with a one-cycle ack per access.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        freeze,
  output logic        mem_stall,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;   // 0 = IF granted last, 1 = MEM granted last
  logic       owner;  // 0 = IF, 1 = MEM
  logic       grant_mem;

  // On a tie the requester that was not served last wins.
  assign grant_mem = mem_req & (~if_req | ~last);

  assign freeze    = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  // The sram_* registers double as the latched request; they are zeroed outside BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b0;
      owner      <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req | mem_req) begin
            owner      <= grant_mem;
            last       <= grant_mem;
            cnt        <= '0;
            sram_en    <= 1'b1;
            sram_we    <= grant_mem & mem_we;
            sram_addr  <= grant_mem ? mem_addr : if_addr;
            sram_wdata <= grant_mem ? mem_wdata : '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            if (owner) begin
              mem_rdata <= sram_we ? '0 : sram_rdata;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= sram_rdata;
              if_ack   <= 1'b1;
            end
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            state      <= ACK;
          end
        end
        ACK: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2; cycle 0 is the IDLE cycle in which a request is seen.
// The SRAM model returns fixed words for 0x10/0x400 and addr^0xA5A5A5A5 elsewhere.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        freeze;
  logic        mem_stall;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .freeze(freeze), .mem_stall(mem_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  assign sram_rdata = !sram_en ? 32'h0 :
                      (sram_addr == 32'h10)  ? 32'hE3A01005 :
                      (sram_addr == 32'h400) ? 32'h11112222 :
                      (sram_addr ^ 32'hA5A5A5A5);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({if_ack, mem_ack, sram_en, sram_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {if_ack, mem_ack, sram_en, sram_we});
    end
    checks++;
    if ({if_rdata, mem_rdata, sram_addr, sram_wdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {if_rdata, mem_rdata, sram_addr, sram_wdata});
    end
    checks++;
    if ({freeze, mem_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_stall got %b exp 00", {freeze, mem_stall});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++;
    if ({freeze, sram_en} !== 2'b10) begin
      errors++; $display("FAIL fetch_c0 got %b exp 10", {freeze, sram_en});
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sram_en, sram_we, sram_addr, if_ack, freeze} !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b1}) begin
        errors++; $display("FAIL fetch_busy c%0d got en=%b we=%b addr=%h ack=%b frz=%b exp 1 0 10 0 1",
                           c, sram_en, sram_we, sram_addr, if_ack, freeze);
      end
    end
    tick();
    checks++;
    if ({if_ack, mem_ack, sram_en, freeze} !== 4'b1000) begin
      errors++; $display("FAIL fetch_ack got %b exp 1000", {if_ack, mem_ack, sram_en, freeze});
    end
    checks++;
    if (if_rdata !== 32'hE3A01005) begin
      errors++; $display("FAIL fetch_rdata got %h exp e3a01005", if_rdata);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if ({if_ack, sram_en, if_rdata} !== {1'b0, 1'b0, 32'hE3A01005}) begin
      errors++; $display("FAIL fetch_hold got ack=%b en=%b rdata=%h exp 0 0 e3a01005", if_ack, sram_en, if_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_mem;
    if_req = 1'b1; if_addr = 32'h30;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h408;
    for (int g = 0; g < 4; g++) begin
      exp_mem = (g % 2 == 0);
      repeat (2) begin
        tick();
        checks++;
        if ({if_ack, mem_ack} !== 2'b00) begin
          errors++; $display("FAIL starve_busy g%0d got %b exp 00", g, {if_ack, mem_ack});
        end
      end
      tick();
      checks++;
      if ({if_ack, mem_ack} !== (exp_mem ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL starve_grant g%0d got %b exp %b", g, {if_ack, mem_ack}, exp_mem ? 2'b01 : 2'b10);
      end
      checks++;
      if (exp_mem ? (mem_rdata !== 32'hA5A5A1AD) : (if_rdata !== 32'hA5A5A595)) begin
        errors++; $display("FAIL starve_rdata g%0d got if=%h mem=%h exp %s", g, if_rdata, mem_rdata,
                           exp_mem ? "mem=a5a5a1ad" : "if=a5a5a595");
      end
      if (g == 3) begin
        if_req = 1'b0; mem_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h404; mem_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({mem_stall, sram_en} !== 2'b10) begin
      errors++; $display("FAIL store_c0 got %b exp 10", {mem_stall, sram_en});
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sram_en, sram_we, sram_addr, sram_wdata, mem_ack} !== {1'b1, 1'b1, 32'h404, 32'hDEADBEEF, 1'b0}) begin
        errors++; $display("FAIL store_busy c%0d got en=%b we=%b addr=%h wdata=%h ack=%b exp 1 1 404 deadbeef 0",
                           c, sram_en, sram_we, sram_addr, sram_wdata, mem_ack);
      end
    end
    tick();
    checks++;
    if ({mem_ack, if_ack, sram_en, sram_we, mem_stall} !== 5'b10000) begin
      errors++; $display("FAIL store_ack got %b exp 10000", {mem_ack, if_ack, sram_en, sram_we, mem_stall});
    end
    checks++;
    if (mem_rdata !== 32'h0) begin
      errors++; $display("FAIL store_rdata got %h exp 0", mem_rdata);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    checks++;
    if ({mem_ack, sram_we, sram_wdata} !== 34'h0) begin
      errors++; $display("FAIL store_after got ack=%b we=%b wdata=%h exp 0 0 0", mem_ack, sram_we, sram_wdata);
    end
  endtask

  task automatic test_churn();
    if_req = 1'b1; if_addr = 32'h50;
    tick();
    if_addr = 32'h60;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h700; mem_wdata = 32'h12345678;
    tick();
    checks++;
    if ({sram_addr, sram_we, sram_wdata} !== {32'h50, 1'b0, 32'h0}) begin
      errors++; $display("FAIL churn_latched got addr=%h we=%b wdata=%h exp 50 0 0", sram_addr, sram_we, sram_wdata);
    end
    tick();
    checks++;
    if ({if_ack, mem_ack, if_rdata} !== {2'b10, 32'hA5A5A5F5}) begin
      errors++; $display("FAIL churn_if_ack got ack=%b%b rdata=%h exp 10 a5a5a5f5", if_ack, mem_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if ({sram_en, if_ack, mem_ack} !== 3'b000) begin
      errors++; $display("FAIL churn_idle got %b exp 000", {sram_en, if_ack, mem_ack});
    end
    tick();
    checks++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== {2'b11, 32'h700, 32'h12345678}) begin
      errors++; $display("FAIL churn_mem_busy got en=%b we=%b addr=%h wdata=%h exp 1 1 700 12345678",
                         sram_en, sram_we, sram_addr, sram_wdata);
    end
    repeat (2) tick();
    checks++;
    if ({if_ack, mem_ack, mem_rdata} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL churn_mem_ack got ack=%b%b rdata=%h exp 01 0", if_ack, mem_ack, mem_rdata);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    checks++;
    if (sram_en !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre got en=%b exp 1", sram_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sram_en, if_ack, sram_addr, if_rdata} !== 66'h0) begin
      errors++; $display("FAIL rstbusy_async got en=%b ack=%b addr=%h rdata=%h exp 0 0 0 0",
                         sram_en, if_ack, sram_addr, if_rdata);
    end
    tick();
    rst = 1'b1;
    checks++;
    if ({sram_en, if_ack} !== 2'b00) begin
      errors++; $display("FAIL rstbusy_held got %b exp 00", {sram_en, if_ack});
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sram_en, sram_addr, if_ack} !== {1'b1, 32'h80, 1'b0}) begin
        errors++; $display("FAIL rstbusy_regrant c%0d got en=%b addr=%h ack=%b exp 1 80 0", c, sram_en, sram_addr, if_ack);
      end
    end
    tick();
    checks++;
    if ({if_ack, if_rdata} !== {1'b1, 32'hA5A5A525}) begin
      errors++; $display("FAIL rstbusy_ack got ack=%b rdata=%h exp 1 a5a5a525", if_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    rst = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
    tick();
    checks++;
    if ({sram_en, if_ack, mem_ack} !== 3'b000) begin
      errors++; $display("FAIL contend_rst got %b exp 000", {sram_en, if_ack, mem_ack});
    end
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sram_en, sram_addr, if_ack, mem_ack} !== {1'b1, 32'h400, 2'b00}) begin
        errors++; $display("FAIL contend_mem_busy c%0d got en=%b addr=%h ack=%b%b exp 1 400 00",
                           c, sram_en, sram_addr, if_ack, mem_ack);
      end
    end
    tick();
    checks++;
    if ({if_ack, mem_ack, mem_rdata} !== {2'b01, 32'h11112222}) begin
      errors++; $display("FAIL contend_mem_ack got ack=%b%b rdata=%h exp 01 11112222", if_ack, mem_ack, mem_rdata);
    end
    mem_req = 1'b0;
    tick();
    checks++;
    if ({sram_en, if_ack, mem_ack, freeze} !== 4'b0001) begin
      errors++; $display("FAIL contend_c4 got %b exp 0001", {sram_en, if_ack, mem_ack, freeze});
    end
    for (int c = 5; c <= 6; c++) begin
      tick();
      checks++;
      if ({sram_en, sram_addr, if_ack, mem_ack} !== {1'b1, 32'h20, 2'b00}) begin
        errors++; $display("FAIL contend_if_busy c%0d got en=%b addr=%h ack=%b%b exp 1 20 00",
                           c, sram_en, sram_addr, if_ack, mem_ack);
      end
    end
    tick();
    checks++;
    if ({if_ack, mem_ack, if_rdata} !== {2'b10, 32'hA5A5A585}) begin
      errors++; $display("FAIL contend_if_ack got ack=%b%b rdata=%h exp 10 a5a5a585", if_ack, mem_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if ({if_ack, mem_ack, sram_en} !== 3'b000) begin
      errors++; $display("FAIL contend_end got %b exp 000", {if_ack, mem_ack, sram_en});
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_store();
    test_churn();
    test_reset_mid_busy();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
